// File: rtl/ccr_flag_unit_if.sv
`default_nettype none
// ccr_flag_unit_if: pipeline-side bundle of the condition-code register stage.
// Rev 1.0
interface ccr_flag_unit_if #(
  parameter int FLAG_W = 4
);
  logic              stall;
  logic              flush;
  logic [FLAG_W-1:0] alu_flags;
  logic              flags_we;
  logic [FLAG_W-1:0] flags_wmask;
  logic              jmp_req;
  logic [1:0]        jmp_cond;
  logic              jmp_taken;
  logic              int_save;
  logic              rti_restore;
  logic [FLAG_W-1:0] flags_q;
  logic              stack_empty;
  logic              stack_full;
  logic              proto_err;

  modport master (
    output stall, flush, alu_flags, flags_we, flags_wmask, jmp_req, jmp_cond,
           int_save, rti_restore,
    input  jmp_taken, flags_q, stack_empty, stack_full, proto_err
  );

  modport slave (
    input  stall, flush, alu_flags, flags_we, flags_wmask, jmp_req, jmp_cond,
           int_save, rti_restore,
    output jmp_taken, flags_q, stack_empty, stack_full, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/ccr_flag_unit.sv
`default_nettype none
// ccr_flag_unit: CCR with jump evaluation/clear and an interrupt flag shadow stack.
// Option CCR_FLAG_BYPASS_EN: jumps see forwarded ALU flags. Rev 1.0
module ccr_flag_unit #(
  parameter int STACK_DEPTH = 2,
  parameter int FLAG_W      = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ccr_flag_unit_if.slave bus
);
  localparam int            PW      = $clog2(STACK_DEPTH + 1);
  localparam logic [PW-1:0] c_depth = PW'(STACK_DEPTH);
  localparam logic [PW-1:0] c_one   = PW'(1);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];

  logic              empty, full, push, wr_en, jmp_taken;
  logic [FLAG_W-1:0] wr_mask, merged, clr_mask, top;
  logic [2:0]        jmp_src;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == c_depth);
  assign wr_en   = bus.flags_we & ~bus.flush;
  assign wr_mask = wr_en ? bus.flags_wmask : '0;
  assign merged  = (bus.alu_flags & wr_mask) | (flags_q & ~wr_mask);

`ifdef CCR_FLAG_BYPASS_EN
  assign jmp_src = merged[2:0];
`else
  assign jmp_src = flags_q[2:0];
`endif

  always_comb begin
    case (bus.jmp_cond)
      2'b01:   jmp_taken = bus.jmp_req & jmp_src[0];
      2'b10:   jmp_taken = bus.jmp_req & jmp_src[1];
      2'b11:   jmp_taken = bus.jmp_req & jmp_src[2];
      default: jmp_taken = bus.jmp_req;
    endcase
  end

  // A taken conditional jump clears the flag it tested; unconditional clears nothing.
  always_comb begin
    clr_mask = '0;
    if (jmp_taken && !bus.flush) begin
      case (bus.jmp_cond)
        2'b01:   clr_mask[0] = 1'b1;
        2'b10:   clr_mask[1] = 1'b1;
        2'b11:   clr_mask[2] = 1'b1;
        default: clr_mask    = '0;
      endcase
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (ptr_q == PW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    flags_d = flags_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    push    = 1'b0;
    if (bus.rti_restore) begin
      if (bus.int_save || empty) err_d = 1'b1;
      if (!empty) begin
        flags_d = top;
        ptr_d   = ptr_q - c_one;
      end
    end else begin
      if (bus.int_save) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push  = 1'b1;
          ptr_d = ptr_q + c_one;
        end
      end
      flags_d = merged & ~clr_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else if (!bus.stall) begin
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Save captures the pre-update CCR, so the same-cycle write lands only in flags_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (!bus.stall && push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (ptr_q == PW'(i)) stack_q[i] <= flags_q;
      end
    end
  end

  assign bus.jmp_taken   = jmp_taken;
  assign bus.flags_q     = flags_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.proto_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ccr_flag_unit.sv
`default_nettype none
// tb_ccr_flag_unit: directed scenarios plus randomized traffic against a queue-based model.
// Rev 1.0
module tb_ccr_flag_unit;
  localparam int DEPTH = 2;
  localparam int FW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ccr_flag_unit_if #(.FLAG_W(FW)) bus();
  ccr_flag_unit #(.STACK_DEPTH(DEPTH), .FLAG_W(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.alu_flags = '0; bus.flags_we = 0;
    bus.flags_wmask = '0; bus.jmp_req = 0; bus.jmp_cond = 2'b00;
    bus.int_save = 0; bus.rti_restore = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    m_flags = '0; m_stack.delete(); m_err = 1'b0;
  endtask

  task automatic write_flags(input logic [3:0] v);
    bus.flags_we = 1; bus.flags_wmask = 4'b1111; bus.alu_flags = v;
    tick();
    idle();
  endtask

  // Reference: flag source for the jump decision.
  function automatic logic model_jmp();
    logic [3:0] src;
    src = m_flags;
`ifdef CCR_FLAG_BYPASS_EN
    if (bus.flags_we && !bus.flush)
      for (int b = 0; b < 4; b++) if (bus.flags_wmask[b]) src[b] = bus.alu_flags[b];
`endif
    if (!bus.jmp_req) return 1'b0;
    case (bus.jmp_cond)
      2'd0:    return 1'b1;
      2'd1:    return src[0];
      2'd2:    return src[1];
      default: return src[2];
    endcase
  endfunction

  task automatic model_update(input logic tk);
    if (bus.stall) return;
    if (bus.rti_restore) begin
      if (bus.int_save) m_err = 1'b1;
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_flags = m_stack.pop_back();
    end else begin
      if (bus.int_save) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_flags);
      end
      if (bus.flags_we && !bus.flush)
        for (int b = 0; b < 4; b++) if (bus.flags_wmask[b]) m_flags[b] = bus.alu_flags[b];
      if (tk && !bus.flush && bus.jmp_cond != 2'd0) m_flags[int'(bus.jmp_cond) - 1] = 1'b0;
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    bus.rti_restore = 1; tick(); idle();
    write_flags(4'b0101);
    bus.int_save = 1; tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0101) begin n_fail++; $display("FAIL pre_reset_flags: got %b want 0101", bus.flags_q); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", bus.flags_q); end
    n_tests++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.stack_empty); end
    n_tests++; if (bus.stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.stack_full); end
    n_tests++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.proto_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    pulse_reset();
    bus.flags_we = 1; bus.flags_wmask = 4'b0011; bus.alu_flags = 4'b0111; bus.flush = 1;
    tick();
    n_tests++; if (bus.flags_q !== 4'b0000) begin n_fail++; $display("FAIL write_flushed: got %b want 0000", bus.flags_q); end
    bus.flush = 0;
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0011) begin n_fail++; $display("FAIL write_masked: got %b want 0011", bus.flags_q); end
  endtask

  task automatic test_jump();
    pulse_reset();
    write_flags(4'b0001);
    bus.jmp_req = 1; bus.jmp_cond = 2'b01; #1;
    n_tests++; if (bus.jmp_taken !== 1'b1) begin n_fail++; $display("FAIL jz_taken: got %b want 1", bus.jmp_taken); end
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0000) begin n_fail++; $display("FAIL jz_clear: got %b want 0000", bus.flags_q); end
    write_flags(4'b1011);
    bus.jmp_req = 1; bus.jmp_cond = 2'b11; #1;
    n_tests++; if (bus.jmp_taken !== 1'b0) begin n_fail++; $display("FAIL jc_not_taken: got %b want 0", bus.jmp_taken); end
    tick();
    n_tests++; if (bus.flags_q !== 4'b1011) begin n_fail++; $display("FAIL jc_hold: got %b want 1011", bus.flags_q); end
    bus.jmp_cond = 2'b00; #1;
    n_tests++; if (bus.jmp_taken !== 1'b1) begin n_fail++; $display("FAIL uncond_taken: got %b want 1", bus.jmp_taken); end
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b1011) begin n_fail++; $display("FAIL uncond_hold: got %b want 1011", bus.flags_q); end
  endtask

  task automatic test_stack();
    pulse_reset();
    write_flags(4'b0100);
    bus.int_save = 1; bus.flags_we = 1; bus.flags_wmask = 4'b1111; bus.alu_flags = 4'b0010;
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0010) begin n_fail++; $display("FAIL save_write: got %b want 0010", bus.flags_q); end
    n_tests++; if (bus.stack_empty !== 1'b0) begin n_fail++; $display("FAIL save_not_empty: got %b want 0", bus.stack_empty); end
    bus.int_save = 1; tick(); idle();
    n_tests++; if (bus.stack_full !== 1'b1) begin n_fail++; $display("FAIL save_full: got %b want 1", bus.stack_full); end
    n_tests++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL save_no_err: got %b want 0", bus.proto_err); end
    bus.int_save = 1; tick(); idle();
    n_tests++; if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", bus.proto_err); end
    write_flags(4'b0000);
    bus.rti_restore = 1; tick();
    n_tests++; if (bus.flags_q !== 4'b0010) begin n_fail++; $display("FAIL rti1: got %b want 0010", bus.flags_q); end
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0100) begin n_fail++; $display("FAIL rti2: got %b want 0100", bus.flags_q); end
    n_tests++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL rti_empty: got %b want 1", bus.stack_empty); end
  endtask

  task automatic test_proto_err();
    pulse_reset();
    write_flags(4'b0110);
    bus.rti_restore = 1; tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0110) begin n_fail++; $display("FAIL rti_empty_hold: got %b want 0110", bus.flags_q); end
    n_tests++; if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL rti_empty_err: got %b want 1", bus.proto_err); end
    pulse_reset();
    write_flags(4'b0110);
    bus.int_save = 1; tick(); idle();
    write_flags(4'b0001);
    bus.int_save = 1; bus.rti_restore = 1;
    bus.flags_we = 1; bus.flags_wmask = 4'b1111; bus.alu_flags = 4'b1111;
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b0110) begin n_fail++; $display("FAIL both_restore: got %b want 0110", bus.flags_q); end
    n_tests++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL both_empty: got %b want 1", bus.stack_empty); end
    n_tests++; if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", bus.proto_err); end
  endtask

  task automatic test_bypass();
    logic       exp_t;
    logic [3:0] exp_f;
`ifdef CCR_FLAG_BYPASS_EN
    exp_t = 1'b1; exp_f = 4'b0000;
`else
    exp_t = 1'b0; exp_f = 4'b0001;
`endif
    pulse_reset();
    bus.flags_we = 1; bus.flags_wmask = 4'b1111; bus.alu_flags = 4'b0001;
    bus.jmp_req = 1; bus.jmp_cond = 2'b01; #1;
    n_tests++; if (bus.jmp_taken !== exp_t) begin n_fail++; $display("FAIL bypass_taken: got %b want %b", bus.jmp_taken, exp_t); end
    tick(); idle();
    n_tests++; if (bus.flags_q !== exp_f) begin n_fail++; $display("FAIL bypass_flags: got %b want %b", bus.flags_q, exp_f); end
  endtask

  task automatic test_stall();
    pulse_reset();
    write_flags(4'b1010);
    bus.stall = 1; bus.int_save = 1; bus.jmp_req = 1; bus.jmp_cond = 2'b10; #1;
    n_tests++; if (bus.jmp_taken !== 1'b1) begin n_fail++; $display("FAIL stall_taken: got %b want 1", bus.jmp_taken); end
    tick(); idle();
    n_tests++; if (bus.flags_q !== 4'b1010) begin n_fail++; $display("FAIL stall_flags: got %b want 1010", bus.flags_q); end
    n_tests++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL stall_empty: got %b want 1", bus.stack_empty); end
  endtask

  task automatic test_random();
    logic tk;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) pulse_reset();
      bus.stall       = ($urandom_range(0, 7) == 0);
      bus.flush       = ($urandom_range(0, 5) == 0);
      bus.flags_we    = $urandom_range(0, 1);
      bus.flags_wmask = 4'($urandom_range(0, 15));
      bus.alu_flags   = 4'($urandom_range(0, 15));
      bus.jmp_req     = $urandom_range(0, 1);
      bus.jmp_cond    = 2'($urandom_range(0, 3));
      bus.int_save    = ($urandom_range(0, 4) == 0);
      bus.rti_restore = ($urandom_range(0, 4) == 0);
      #1;
      tk = model_jmp();
      n_tests++; if (bus.jmp_taken !== tk) begin n_fail++; $display("FAIL rnd_jmp[%0d]: got %b want %b", i, bus.jmp_taken, tk); end
      model_update(tk);
      tick();
      n_tests++; if (bus.flags_q !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, bus.flags_q, m_flags); end
      n_tests++; if (bus.stack_empty !== (m_stack.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, bus.stack_empty, m_stack.size() == 0); end
      n_tests++; if (bus.stack_full !== (m_stack.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, bus.stack_full, m_stack.size() == DEPTH); end
      n_tests++; if (bus.proto_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, bus.proto_err, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_write();
    test_jump();
    test_stack();
    test_proto_err();
    test_bypass();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/ccr_flag_unit.md
Name: ccr_flag_unit

Overview:
- Condition-code register (CCR) stage directly downstream of the ALU in the execute stage.
- Latches the 4-bit ALU flag vector (bit0 Z, bit1 N, bit2 C, bit3 reserved) and feeds it back to the ALU as its flags input.
- Evaluates conditional jumps and clears the tested flag on a taken jump.
- Keeps a small shadow stack that saves flags on interrupt entry and restores them on RTI.

Parameters:
- STACK_DEPTH, 2, number of nested interrupt flag-save entries (≥1).
- FLAG_W, 4, flag vector width; bit mapping fixed for bits 0-2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze all state; outputs hold.
- flush  in  1  squash this cycle's flag write and jump clear; save and restore still act.
- alu_flags  in  FLAG_W  flags_out from ALU.
- flags_we  in  1  write CCR from alu_flags.
- flags_wmask  in  FLAG_W  per-bit write enable, qualified by flags_we.
- jmp_req  in  1  jump instruction in EX.
- jmp_cond  in  2  00 uncond, 01 JZ, 10 JN, 11 JC.
- jmp_taken  out  1  combinational jump decision.
- int_save  in  1  push CCR onto shadow stack.
- rti_restore  in  1  pop shadow stack into CCR.
- flags_q  out  FLAG_W  registered CCR; drives ALU flags_in.
- stack_empty  out  1  no saved entries.
- stack_full  out  1  STACK_DEPTH entries saved.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1): flags_q=0, stack pointer=0, all stack entries=0, stack_empty=1, stack_full=0, proto_err=0. Reset mid-operation discards pending save/restore.
- stall=1: no register changes. jmp_taken still evaluates.
- jmp_taken = jmp_req & (cond==00 | (cond==01 & Z) | (cond==10 & N) | (cond==11 & C)), using the flag source defined under Optional Feature.
- Update order in one non-stalled cycle:
  1. rti_restore (highest priority).
  2. int_save.
  3. ALU write.
  4. Jump clear.
- rti_restore, stack not empty: CCR <= top entry, pointer-1; ALU write and jump clear ignored this cycle.
- rti_restore, stack empty: CCR unchanged, proto_err <= 1.
- int_save, stack not full: push current flags_q (pre-update value), pointer+1. The ALU write and jump clear still apply to the CCR in the same cycle.
- int_save, stack full: push dropped, contents unchanged, proto_err <= 1; write and clear still apply.
- int_save and rti_restore together: restore executes, save ignored, proto_err <= 1.
- ALU write (flags_we & !flush): for each bit i with flags_wmask[i]=1, CCR[i] <= alu_flags[i]; masked-off bits hold.
- Jump clear (jmp_taken & !flush, cond≠00): tested bit cleared at the edge. Overrides an ALU write to that same bit; other written bits apply. Bit3 is never cleared.
- Stack is LIFO with a pointer 0..STACK_DEPTH; no wrap-around.
- stack_empty = (ptr==0), stack_full = (ptr==STACK_DEPTH); both registered-derived.
- proto_err cleared only by rst.
- Latency: CCR writes, save and restore visible on flags_q one cycle after the edge. jmp_taken has zero latency.

Optional Feature:
- Macro: CCR_FLAG_BYPASS_EN.
- Defined: jmp_taken evaluates against forwarded flags, i.e. alu_flags masked by flags_wmask when flags_we & !flush, else flags_q per bit. Allows a jump right behind a flag-setting instruction without a bubble.
- Undefined: jmp_taken uses flags_q only. The upstream hazard unit inserts one stall between a flag write and a dependent jump.

Test Plan:
- Reset mid-cycle with flags_q=4'b0101 and ptr=1 -> immediately flags_q=0, stack_empty=1, proto_err=0.
- flags_we=1, wmask=4'b0011, alu_flags=4'b0111, prior CCR=0 -> flags_q=4'b0011 (C unchanged at 0). Same with flush=1 -> flags_q stays 0.
- CCR=4'b0001, jmp_req=1, cond=01 -> jmp_taken=1; next cycle flags_q=4'b0000. cond=11 with C=0 -> jmp_taken=0, CCR unchanged.
- STACK_DEPTH=2, pushes with CCR 4'b0100 then 4'b0010, third push -> stack_full=1, proto_err=1. Two RTIs -> flags_q 4'b0010 then 4'b0100, stack_empty=1.
- RTI on empty stack -> flags_q unchanged, proto_err=1. int_save+rti_restore together with ptr=1 -> restore applied, ptr=0, proto_err=1.
- With CCR_FLAG_BYPASS_EN: CCR=0, flags_we=1, wmask=4'b1111, alu_flags=4'b0001, jmp_req=1, cond=01 -> jmp_taken=1 in the same cycle, and Z cleared at the edge (flags_q=0). Without the macro -> jmp_taken=0, flags_q=4'b0001.
